// File: rtl/preg_fre_lst_pkg.sv
// preg_fre_lst_pkg: shared sizes, the {vld, idx} preg field and the reset free-map constant
package preg_fre_lst_pkg;
  localparam int NUM_PREG     = 64;
  localparam int PREG_BITS    = 6;
  localparam int NUM_ARCH_REG = 16;
  localparam int ISQ_DEPTH    = 64;
  localparam int ALC_PORTS    = 4;
  localparam int FLD_BITS     = PREG_BITS + 1;
  typedef struct packed {
    logic                 vld;
    logic [PREG_BITS-1:0] idx;
  } preg_fld_t;
  localparam logic [NUM_PREG-1:0] RST_FRE_MAP = {{(NUM_PREG-NUM_ARCH_REG){1'b1}}, {NUM_ARCH_REG{1'b0}}};
endpackage

// File: rtl/preg_fre_lst_ffs.sv
// preg_fre_lst_ffs: 64-bit find-first-set returning {found, lowest set index}
module preg_fre_lst_ffs
  import preg_fre_lst_pkg::*;
(
  input  logic [NUM_PREG-1:0]  i_vec,
  output logic                 o_fnd,
  output logic [PREG_BITS-1:0] o_idx
);
  // scan from the top so the lowest set bit is the last one to win
  always_comb begin
    o_fnd = |i_vec;
    o_idx = '0;
    for (int i = NUM_PREG - 1; i >= 0; i--) if (i_vec[i]) o_idx = PREG_BITS'(i);
  end
endmodule

// File: rtl/preg_fre_lst.sv
// preg_fre_lst: physical-register free list with all-or-nothing multi-port allocation and bulk release
module preg_fre_lst
  import preg_fre_lst_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FLD_BITS*ISQ_DEPTH-1:0]  i_fre_preg_flat,
  input  logic [ISQ_DEPTH-1:0]           i_fre_en,
  input  logic [ALC_PORTS-1:0]           i_alc_req,
  output logic [ALC_PORTS-1:0]           o_alc_vld,
  output logic [PREG_BITS*ALC_PORTS-1:0] o_alc_preg_flat,
  output logic                           o_alc_stl,
  output logic [PREG_BITS:0]             o_fre_cnt,
  output logic                           o_fre_lst_emp,
  output logic                           o_dbl_fre_err
);
  localparam int REQ_BITS = $clog2(ALC_PORTS + 1);
  localparam int LVLS     = $clog2(NUM_PREG);
  logic [NUM_PREG-1:0]  r_fre_map;
  logic [PREG_BITS:0]   r_fre_cnt;
  logic                 r_dbl_fre_err;
  logic [NUM_PREG-1:0]  w_msk [0:ALC_PORTS];
  logic                 w_fnd [0:ALC_PORTS-1];
  logic [PREG_BITS-1:0] w_idx [0:ALC_PORTS-1];
  logic [REQ_BITS-1:0]  w_req_n;
  logic                 w_ok;
  logic [NUM_PREG-1:0]  w_gnt;
  logic [NUM_PREG-1:0]  w_rel;
  logic [NUM_PREG-1:0]  w_nxt;
  logic [PREG_BITS:0]   w_nxt_cnt;
  logic                 w_dbl;
  preg_fld_t            w_fld;

  assign w_msk[0] = r_fre_map;

  // each requesting slot takes the lowest reg left after the slots below it
  for (genvar j = 0; j < ALC_PORTS; j++) begin : g_alc
    preg_fre_lst_ffs u_ffs (.i_vec(w_msk[j]), .o_fnd(w_fnd[j]), .o_idx(w_idx[j]));
    assign w_msk[j+1] = (i_alc_req[j] && w_fnd[j]) ? (w_msk[j] & ~(NUM_PREG'(1) << w_idx[j])) : w_msk[j];
    assign o_alc_vld[j] = i_alc_req[j] & w_ok;
    assign o_alc_preg_flat[PREG_BITS*j +: PREG_BITS] = o_alc_vld[j] ? w_idx[j] : '0;
  end

  // number of slots asking this cycle
  always_comb begin
    w_req_n = '0;
    for (int j = 0; j < ALC_PORTS; j++) w_req_n = w_req_n + REQ_BITS'(i_alc_req[j]);
  end

  assign w_ok  = {{(PREG_BITS+1-REQ_BITS){1'b0}}, w_req_n} <= r_fre_cnt;
  assign w_gnt = w_ok ? (r_fre_map & ~w_msk[ALC_PORTS]) : '0;

  // OR together the one-hot decode of every valid, enabled release line
  always_comb begin
    w_rel = '0;
    w_fld = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      w_fld = preg_fld_t'(i_fre_preg_flat[FLD_BITS*i +: FLD_BITS]);
      if (i_fre_en[i] && w_fld.vld) w_rel = w_rel | (NUM_PREG'(1) << w_fld.idx);
    end
  end

  assign w_nxt = (r_fre_map & ~w_gnt) | w_rel;
  assign w_dbl = |(w_rel & r_fre_map & ~w_gnt);

  for (genvar l = 0; l <= LVLS; l++) begin : g_pc
    logic [(NUM_PREG>>l)-1:0][PREG_BITS:0] s;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NUM_PREG; i++) begin : g_bit
        assign s[i] = {{PREG_BITS{1'b0}}, w_nxt[i]};
      end
    end else begin : g_add
      for (genvar i = 0; i < (NUM_PREG >> l); i++) begin : g_sum
        assign s[i] = g_pc[l-1].s[2*i] + g_pc[l-1].s[2*i+1];
      end
    end
  end
  assign w_nxt_cnt = g_pc[LVLS].s[0];

  // free map, its population count and the sticky double-free flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fre_map     <= RST_FRE_MAP;
      r_fre_cnt     <= (PREG_BITS+1)'(NUM_PREG - NUM_ARCH_REG);
      r_dbl_fre_err <= 1'b0;
    end else begin
      r_fre_map     <= w_nxt;
      r_fre_cnt     <= w_nxt_cnt;
      r_dbl_fre_err <= r_dbl_fre_err | w_dbl;
    end
  end

  assign o_alc_stl     = ~w_ok;
  assign o_fre_cnt     = r_fre_cnt;
  assign o_fre_lst_emp = (r_fre_cnt == '0);
  assign o_dbl_fre_err = r_dbl_fre_err;
endmodule

// File: tb/tb_preg_fre_lst.sv
// tb_preg_fre_lst: randomized and directed checks of the free list against a behavioural model
module tb_preg_fre_lst;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [447:0] fre_flat;
  logic [63:0]  fre_en;
  logic [3:0]   alc_req;
  logic [3:0]   alc_vld;
  logic [23:0]  alc_preg;
  logic         alc_stl;
  logic [6:0]   fre_cnt;
  logic         emp;
  logic         dbl;

  int n_vec = 0;
  int n_err = 0;

  bit          m_free [64];
  bit          m_err;
  bit          e_gnt  [64];
  int          e_cnt;
  bit          e_stl;
  logic [3:0]  e_vld;
  logic [23:0] e_preg;

  preg_fre_lst dut (
    .clk(clk), .rst_n(rst_n), .i_fre_preg_flat(fre_flat), .i_fre_en(fre_en), .i_alc_req(alc_req),
    .o_alc_vld(alc_vld), .o_alc_preg_flat(alc_preg), .o_alc_stl(alc_stl), .o_fre_cnt(fre_cnt),
    .o_fre_lst_emp(emp), .o_dbl_fre_err(dbl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_free[i] = (i >= 16);
    m_err = 0;
  endtask

  // expected grants: k-th requester gets the k-th lowest free reg, only if all fit
  task automatic mdl();
    int n = 0;
    int k = 0;
    e_cnt = 0;
    for (int j = 0; j < 4; j++) n += int'(alc_req[j]);
    for (int i = 0; i < 64; i++) begin
      e_cnt += int'(m_free[i]);
      e_gnt[i] = 0;
    end
    e_stl  = n > e_cnt;
    e_vld  = '0;
    e_preg = '0;
    if (!e_stl)
      for (int j = 0; j < 4; j++)
        if (alc_req[j]) begin
          int seen = 0;
          for (int i = 0; i < 64; i++)
            if (m_free[i]) begin
              if (seen == k) begin
                e_preg[6*j +: 6] = 6'(i);
                e_gnt[i] = 1;
              end
              seen++;
            end
          e_vld[j] = 1'b1;
          k++;
        end
  endtask

  task automatic cmp();
    mdl();
    chk("alc_vld", 64'(alc_vld), 64'(e_vld));
    chk("alc_preg", 64'(alc_preg), 64'(e_preg));
    chk("alc_stl", 64'(alc_stl), 64'(e_stl));
    chk("fre_cnt", 64'(fre_cnt), 64'(e_cnt));
    chk("fre_lst_emp", 64'(emp), 64'(e_cnt == 0));
    chk("dbl_fre_err", 64'(dbl), 64'(m_err));
  endtask

  task automatic adv();
    bit rel [64];
    bit nf  [64];
    bit ne;
    int idx;
    mdl();
    ne = m_err;
    for (int i = 0; i < 64; i++) rel[i] = 0;
    for (int l = 0; l < 64; l++)
      if (fre_en[l] && fre_flat[7*l+6]) begin
        idx = int'(fre_flat[7*l +: 6]);
        rel[idx] = 1;
      end
    for (int i = 0; i < 64; i++) begin
      if (rel[i] && m_free[i] && !e_gnt[i]) ne = 1;
      nf[i] = (m_free[i] && !e_gnt[i]) || rel[i];
    end
    @(posedge clk);
    #1;
    m_free = nf;
    m_err  = ne;
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp();
  endtask

  task automatic step();
    cyc();
    adv();
  endtask

  task automatic set_rel(input int line, input bit en, input bit vld, input int idx);
    fre_en[line] = en;
    fre_flat[7*line +: 7] = {vld, 6'(idx)};
  endtask

  task automatic clr_rel();
    fre_en   = '0;
    fre_flat = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    alc_req = '0;
    clr_rel();
    m_reset();
    repeat (2) @(posedge clk);
    cyc();
    chk("rst_cnt", 64'(fre_cnt), 64'd48);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    alc_req = 4'b1010;
    cyc();
    chk("t2_vld", 64'(alc_vld), 64'b1010);
    chk("t2_preg", 64'(alc_preg), 64'({6'd17, 6'd0, 6'd16, 6'd0}));
    alc_req = 4'b1111;
    #1;
    cmp();
    chk("t1_preg", 64'(alc_preg), 64'({6'd19, 6'd18, 6'd17, 6'd16}));
    adv();
    alc_req = 4'b0000;
    cyc();
    chk("t1_cnt", 64'(fre_cnt), 64'd44);
    adv();

    alc_req = 4'b1111;
    repeat (10) step();
    alc_req = 4'b0011;
    step();
    alc_req = 4'b0111;
    cyc();
    chk("drain_cnt", 64'(fre_cnt), 64'd2);
    chk("stall", 64'({alc_stl, alc_vld}), 64'b10000);
    adv();
    alc_req = 4'b0011;
    step();
    alc_req = 4'b0000;
    cyc();
    chk("emp", 64'(emp), 64'd1);
    adv();

    alc_req = 4'b0001;
    set_rel(3, 1, 1, 5);
    set_rel(60, 1, 1, 40);
    cyc();
    chk("emp_stl", 64'(alc_stl), 64'd1);
    adv();
    clr_rel();
    cyc();
    chk("rel_gnt", 64'({alc_vld, alc_preg}), 64'({4'b0001, 24'd5}));
    chk("rel_cnt", 64'(fre_cnt), 64'd2);
    adv();
    alc_req = 4'b0000;
    cyc();
    chk("rel_cnt1", 64'(fre_cnt), 64'd1);
    adv();

    set_rel(0, 1, 1, 20);
    step();
    clr_rel();
    set_rel(0, 1, 1, 20);
    step();
    clr_rel();
    cyc();
    chk("dbl_set", 64'(dbl), 64'd1);
    chk("dbl_cnt", 64'(fre_cnt), 64'd2);
    adv();

    set_rel(7, 1, 0, 3);
    set_rel(8, 0, 1, 4);
    step();
    clr_rel();
    cyc();
    chk("novld_cnt", 64'(fre_cnt), 64'd2);
    adv();

    for (int c = 0; c < 400; c++) begin
      alc_req = 4'($urandom_range(0, 15));
      for (int l = 0; l < 64; l++)
        set_rel(l, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 63)));
      step();
    end
    clr_rel();
    chk("dbl_hold", 64'(dbl), 64'd1);

    alc_req = 4'b0000;
    for (int l = 0; l < 64; l++) set_rel(l, 1, 1, l);
    step();
    cyc();
    chk("flush_cnt", 64'(fre_cnt), 64'd64);
    #2;
    rst_n = 1'b0;
    m_reset();
    clr_rel();
    #1;
    chk("mid_rst_cnt", 64'(fre_cnt), 64'd48);
    chk("mid_rst_dbl", 64'(dbl), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    alc_req = 4'b1111;
    cyc();
    chk("post_rst_preg", 64'(alc_preg), 64'({6'd19, 6'd18, 6'd17, 6'd16}));
    adv();
    alc_req = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
